// File: rtl/ov7670_stream_gen.sv
// OV7670-style RGB444 pixel stream generator: vsync/href/byte timing plus test patterns.
// Stands in for the camera so the capture and display path can be exercised with known images.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned LINE   = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_L  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned COL_W  = $clog2(LINE + 1);
  localparam int unsigned LINE_W = $clog2(MAX_L + 1);
  localparam int unsigned BAR_W  = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  last_line;
  logic [1:0]         pat_q, pat_d;
  logic [11:0]        solid_q, solid_d;
  logic               line_end;

  logic               vsync_q, href_q, fd_q;
  logic [7:0]         d_q, cnt_q;
  logic               vsync_d, href_d, fd_d;
  logic [7:0]         d_d, cnt_d;

  logic [COL_W-1:0]   x;
  logic [4:0]         x_lo, y_lo;
  logic [31:0]        bar;
  logic [11:0]        rgb;

  // Frame sequencer: col sweeps each line, line counts within the current state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    case (state_q)
      VSYNC:   last_line = LINE_W'(VSYNC_LINES - 1);
      VBACK:   last_line = LINE_W'(V_BACK - 1);
      ACTIVE:  last_line = LINE_W'(V_ACTIVE - 1);
      VFRONT:  last_line = LINE_W'(V_FRONT - 1);
      default: last_line = '0;
    endcase
    line_end = (col_q == COL_W'(LINE - 1));

    if (state_q == IDLE) begin
      if (enable) begin
        state_d = VSYNC;
        col_d   = '0;
        line_d  = '0;
        pat_d   = pattern_sel;
        solid_d = solid_rgb;
      end
    end else if (line_end) begin
      col_d = '0;
      if (line_q == last_line) begin
        line_d = '0;
        case (state_q)
          VSYNC:  state_d = VBACK;
          VBACK:  state_d = ACTIVE;
          ACTIVE: state_d = VFRONT;
          default: begin
            if (enable) begin
              state_d = VSYNC;
              pat_d   = pattern_sel;
              solid_d = solid_rgb;
            end else begin
              state_d = IDLE;
            end
          end
        endcase
      end else begin
        line_d = line_q + LINE_W'(1);
      end
    end else begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Outputs are decoded from the next state so every output register lines up with its cycle.
  always_comb begin
    x    = col_d >> 1;
    x_lo = 5'(col_d >> 1);
    y_lo = 5'(line_d);
    bar  = 32'(x) / BAR_W;
    rgb  = 12'h000;
    case (pat_d)
      2'd0: begin
        case (bar)
          32'd0:   rgb = 12'hFFF;
          32'd1:   rgb = 12'hFF0;
          32'd2:   rgb = 12'h0FF;
          32'd3:   rgb = 12'h0F0;
          32'd4:   rgb = 12'hF0F;
          32'd5:   rgb = 12'hF00;
          32'd6:   rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd1:    rgb = solid_q;
      2'd2:    rgb = {x_lo[3:0], y_lo[3:0], cnt_q[3:0]};
      default: rgb = (x_lo[4] ^ y_lo[4]) ? 12'hFFF : 12'h000;
    endcase
    if (pat_d == 2'd1) rgb = solid_d;

    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == ACTIVE) && (col_d < COL_W'(2 * H_ACTIVE));
    d_d     = href_d ? (col_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]}) : 8'h00;
    fd_d    = (state_d == VFRONT) && (line_d == LINE_W'(V_FRONT - 1)) &&
              (col_d == COL_W'(LINE - 1));
    cnt_d   = fd_d ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
      fd_q    <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      d_q     <= d_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign d          = d_q;
  assign frame_done = fd_q;
  assign frame_cnt  = cnt_q;

endmodule
